// File: rtl/pipes_pkg.sv
// Shared pipeline types.
//   fetch_data_t : completed fetch bundle handed from fetch to decode
//   FQ_DEPTH     : entry count used when instantiating fetch_queue at top level
package pipes;

  localparam int FQ_DEPTH = 4;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] raw_instr;
    logic        valid;
  } fetch_data_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: decoupling FIFO between fetch and decode.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   in_valid     : fetch offers in_data (only pushed if in_data.valid)
//   in_data      : fetch bundle
//   in_ready     : queue has room (depends only on registered occupancy)
//   out_valid    : head entry available
//   out_data     : head entry, '0 while empty
//   out_ready    : decode consumes head
//   flush        : redirect, drop everything (beats push/pop)
//   count        : occupancy 0..DEPTH
//   pc_stall     : ~in_ready, holds the PC register
module fetch_queue
  import pipes::*;
#(
  parameter  int DEPTH = FQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  fetch_data_t      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output fetch_data_t      out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [PTR_W:0]   count,
  output logic             pc_stall
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  fetch_data_t      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   cnt;
  logic             push, pop;

  // Handshake outputs come from registered occupancy only, so there is no
  // combinational path out_ready->in_ready or in_valid->out_valid. A full
  // queue refuses a push even when a pop happens in the same cycle.
  assign in_ready  = (cnt != FULL);
  assign out_valid = (cnt != '0);
  assign pc_stall  = ~in_ready;
  assign count     = cnt;

  assign push = in_valid & in_data.valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      out_data       = mem[rd_ptr];
      out_data.valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  import pipes::*;

  localparam int DEPTH = FQ_DEPTH;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready, flush;
  fetch_data_t in_data, out_data;
  logic        in_ready, out_valid, pc_stall;
  logic [2:0]  count;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .flush(flush), .count(count), .pc_stall(pc_stall)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  fetch_data_t model_q[$];   // reference contents, head at index 0
  logic [63:0] seen_pc[$];   // pcs the DUT handed to decode

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    fetch_data_t e;
    e = '0;
    if (model_q.size() != 0) begin
      e = model_q[0];
      e.valid = 1'b1;
    end
    chk("count",     128'(count),     128'(model_q.size()));
    chk("out_valid", 128'(out_valid), 128'(model_q.size() != 0));
    chk("in_ready",  128'(in_ready),  128'(model_q.size() != DEPTH));
    chk("pc_stall",  128'(pc_stall),  128'(model_q.size() == DEPTH));
    chk("out_data",  128'(out_data),  128'(e));
  endtask

  // One clock: drive inputs, note what the DUT hands out, advance the model.
  // Returns whether the model accepted the push.
  task automatic cyc(input logic iv, input logic [63:0] pc, input logic [31:0] raw,
                     input logic dv, input logic ordy, input logic fl, input logic rst,
                     output logic acc);
    logic do_push, do_pop;
    fetch_data_t d;
    d.pc = pc; d.raw_instr = raw; d.valid = dv;
    reset = rst; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    do_pop  = !rst && !fl && ordy && model_q.size() > 0;
    do_push = !rst && !fl && iv && dv && model_q.size() < DEPTH;
    if (do_pop && out_valid) seen_pc.push_back(out_data.pc);
    @(posedge clk);
    #1;
    if (rst || fl) model_q.delete();
    else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(d);
    end
    acc = do_push;
    check_all();
  endtask

  logic acc;
  int   n;

  initial begin
    reset = 1; flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
    // reset then idle
    cyc(0, 0, 0, 0, 0, 0, 1, acc);
    cyc(0, 0, 0, 0, 0, 0, 1, acc);
    cyc(0, 0, 0, 0, 0, 0, 0, acc);
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_data",  128'(out_data), 128'(0));

    // single pass-through
    cyc(1, BASE, 32'h13, 1, 1, 0, 0, acc);
    chk("pt_pc",  128'(out_data.pc), 128'(BASE));
    chk("pt_raw", 128'(out_data.raw_instr), 128'(32'h13));
    cyc(0, 0, 0, 0, 1, 0, 0, acc);
    chk("pt_drain", 128'(count), 128'(0));

    // fill and backpressure
    seen_pc.delete();
    for (int i = 0; i < 4; i++) cyc(1, BASE + 64'(4*i), 32'h13, 1, 0, 0, 0, acc);
    chk("full_cnt", 128'(count), 128'(4));
    chk("full_stall", 128'(pc_stall), 128'(1));
    cyc(1, BASE + 64'h10, 32'h13, 1, 0, 0, 0, acc);
    chk("full_refuse", 128'(count), 128'(4));
    cyc(1, BASE + 64'h10, 32'h13, 1, 1, 0, 0, acc);
    chk("full_poppush", 128'(count), 128'(3));
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0, 0, acc);
    for (int i = 0; i < 4; i++)
      chk("fill_order", 128'(i < seen_pc.size() ? seen_pc[i] : 64'hx), 128'(BASE + 64'(4*i)));

    // wrap-around with toggling out_ready
    seen_pc.delete();
    n = 0;
    for (int c = 0; c < 200 && (n < 10 || model_q.size() != 0); c++) begin
      cyc(n < 10, BASE + 64'(4*n), 32'h13, 1, c[0] == 1'b0, 0, 0, acc);
      if (acc) n++;
    end
    chk("wrap_len", 128'(seen_pc.size()), 128'(10));
    for (int i = 0; i < 10; i++)
      chk("wrap_pc", 128'(i < seen_pc.size() ? seen_pc[i] : 64'hx), 128'(BASE + 64'(4*i)));

    // flush with simultaneous push and pop
    seen_pc.delete();
    for (int i = 0; i < 3; i++) cyc(1, BASE + 64'(4*i), 32'h13, 1, 0, 0, 0, acc);
    chk("pre_flush", 128'(count), 128'(3));
    cyc(1, BASE + 64'h100, 32'h13, 1, 1, 1, 0, acc);
    chk("flush_cnt",   128'(count), 128'(0));
    chk("flush_ready", 128'(in_ready), 128'(1));
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0, 0, acc);
    chk("flush_noout", 128'(seen_pc.size()), 128'(0));

    // invalid bundle
    cyc(1, BASE, 32'h13, 1, 0, 0, 0, acc);
    cyc(1, BASE + 64'h40, 32'h13, 0, 0, 0, 0, acc);
    chk("inv_cnt", 128'(count), 128'(1));
    cyc(0, 0, 0, 0, 1, 0, 0, acc);

    // randomized traffic including flush and mid-stream reset
    for (int c = 0; c < 600; c++) begin
      cyc($urandom_range(0, 3) != 0, {32'h0, $urandom}, $urandom,
          $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0, acc);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling FIFO between the fetch stage and the decode stage.
- Accepts completed fetch_data_t bundles (pc, raw_instr, valid) from fetch. Holds up to DEPTH of them and presents them in program order to decode with a valid/ready handshake.
- Asserts backpressure so the PC register holds while the queue is full.
- Discards all contents on a pipeline redirect (branch mispredict, jalr resolution).

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- PTR_W, $clog2(DEPTH), read/write pointer width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch offers a completed bundle (fetch data_ok seen, imem not waiting).
- in_data  input  fetch_data_t  bundle from fetch: pc 64, raw_instr 32, valid 1.
- in_ready  output  1  queue accepts a push this cycle.
- out_valid  output  1  head entry available to decode.
- out_data  output  fetch_data_t  head entry.
- out_ready  input  1  decode consumes the head this cycle.
- flush  input  1  redirect; discard everything.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.
- pc_stall  output  1  equals ~in_ready; holds the PC register.

Behaviour:
- Reset (synchronous, reset high at posedge):
  - rd_ptr=0, wr_ptr=0, count=0, out_valid=0, in_ready=1, pc_stall=0.
  - out_data is driven '0 while empty.
  - Storage contents are don't-care.
- Push:
  - Occurs when in_valid & in_ready & ~flush.
  - Writes in_data at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap of PTR_W bits).
- Pop:
  - Occurs when out_valid & out_ready & ~flush.
  - rd_ptr increments modulo DEPTH.
- Flow-through latency:
  - An entry pushed in cycle N is visible on out_data/out_valid in cycle N+1 at the earliest.
  - No same-cycle bypass from in_data to out_data.
- in_ready:
  - in_ready = (count != DEPTH); combinational from registered count only.
  - When full, a push is refused even if a pop occurs in the same cycle. Fetch retries next cycle.
- out_valid:
  - out_valid = (count != 0).
  - out_data = storage[rd_ptr] when out_valid, else '0.
  - out_data.valid forced 1 for stored entries.
- Occupancy:
  - count next = count + push - pop.
  - Push and pop together when 0 < count < DEPTH leaves count unchanged.
- Empty + out_ready:
  - No pop; pointers unchanged.
- Entries with in_data.valid=0:
  - Never pushed. The push condition also requires in_data.valid.
- Flush:
  - Highest priority over push, pop and simultaneous events.
  - At the next edge: rd_ptr=wr_ptr=0 and count=0.
  - Any push or pop presented in the flush cycle is dropped.
  - The cycle after flush: out_valid=0, in_ready=1.
- Reset has priority over flush. Reset mid-stream drops all entries with no output pulse.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.
- Ordering:
  - Strict FIFO; pc sequence out equals pc sequence of accepted pushes since the last flush/reset.

Decomposition:
- fetch_data_t stays in the pipes package.
- Add constant FQ_DEPTH (default 4) to pipes for the top-level instantiation.
- No sub-module needed. Storage is a register array indexed by pointers, all control in one always_ff plus one always_comb.

Test Plan:
- Reset then idle: reset high 2 cycles, then low → count=0, out_valid=0, in_ready=1, pc_stall=0, out_data='0.
- Single pass-through: push {pc=0x8000_0000, raw=0x0000_0013} with out_ready=1 → out_valid=1 next cycle with the same pc/raw; count 1 then 0 after the pop.
- Fill and backpressure (DEPTH=4): push pcs 0x8000_0000, +4, +8, +C with out_ready=0 → count=4, in_ready=0, pc_stall=1. A fifth push of pc+0x10 is not stored. A pop plus push in the same full cycle leaves count=3 and drops the push.
- Wrap-around: push/pop 10 sequential pcs from 0x8000_0000 with out_ready toggling 1,0,1,... → output pcs exactly 0x8000_0000..0x8000_0024 in order, no duplicates or losses.
- Flush with simultaneous push/pop: count=3, assert flush together with in_valid (pc 0x8000_0100) and out_ready → next cycle count=0, out_valid=0, in_ready=1; pc 0x8000_0100 never appears at the output.
- Invalid bundle: in_valid=1 with in_data.valid=0 → no push, count unchanged.
